decade_ctrl: RTL and testbench

DECADE_CTRL -- requirements
Module: decade_ctrl

---
 rtl/decade_pkg.sv | 26 ++
 rtl/decade_mirror.sv | 26 ++
 rtl/decade_ctrl.sv | 142 ++++++++++++++
 tb/tb_decade_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decade_pkg.sv
// Shared constants, mode encodings and FSM states for the decade counter controller.
package decade_pkg;

    localparam logic [3:0] MAX_DIGIT   = 4'd9;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        TURN,
        DONE
    } state_t;

    // One mod-10 step in the requested direction.
    function automatic logic [3:0] digit_step(input logic [3:0] v, input logic up);
        if (up)
            digit_step = (v >= MAX_DIGIT) ? 4'd0 : v + 4'd1;
        else
            digit_step = (v == 4'd0) ? MAX_DIGIT : v - 4'd1;
    endfunction

endpackage

// File: rtl/decade_mirror.sv
// Reference decade count kept alongside the external counter, stepped by the same controls.
module decade_mirror
    import decade_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       enable,
    input  logic       up,
    output logic [3:0] value,
    output logic       tc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            value <= 4'd0;
        else if (load)
            value <= load_val;
        else if (enable)
            value <= digit_step(value, up);
    end

    assign tc = up ? (value == MAX_DIGIT) : (value == 4'd0);

endmodule

// File: rtl/decade_ctrl.sv
// Sequencer for an external decade counter: load, run a number of terminal-count passes,
// optionally bounce direction, and flag any divergence from the internal mirror.
module decade_ctrl
    import decade_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] preset,
    input  logic [1:0] mode,
    input  logic [3:0] passes,
    input  logic       tc_in,
    input  logic [3:0] count_in,
    output logic       load,
    output logic [3:0] data_out,
    output logic       counter_on,
    output logic       count_up,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     state, state_n;
    logic [3:0] pass_cnt;
    logic       dir_q;
    logic       err_q;
    logic [3:0] preset_q;
    logic [1:0] mode_q;
    logic [3:0] passes_q;
    logic [3:0] mirror_val;
    logic       mirror_tc;
    logic       accept;
    logic       last_pass;
    logic       mismatch;

    assign accept = (preset <= MAX_DIGIT) && (passes != 4'd0) &&
                    ((mode == MODE_UP) || (mode == MODE_DOWN) || (mode == MODE_BOUNCE));

    // Widened so passes=15 compares without wrapping.
    assign last_pass = ({1'b0, pass_cnt} + 5'd1) == {1'b0, passes_q};

    assign mismatch = (count_in != mirror_val) || (tc_in != mirror_tc);

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        data_out   = 4'd0;
        counter_on = 1'b0;
        count_up   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && accept)
                    state_n = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                data_out = preset_q;
                busy     = 1'b1;
                count_up = dir_q;
                state_n  = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                count_up   = dir_q;
                counter_on = 1'b1;
                if (tc_in) begin
                    if (last_pass) begin
                        counter_on = 1'b0;
                        state_n    = DONE;
                    end else if (mode_q == MODE_BOUNCE) begin
                        counter_on = 1'b0;
                        state_n    = TURN;
                    end
                end
            end
            TURN: begin
                busy     = 1'b1;
                count_up = dir_q;
                state_n  = RUN;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pass_cnt <= 4'd0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start && !abort) begin
                if (accept) begin
                    err_q    <= 1'b0;
                    pass_cnt <= 4'd0;
                    dir_q    <= (mode != MODE_DOWN);
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state == RUN && tc_in)
                pass_cnt <= pass_cnt + 4'd1;
            if (state == TURN && !abort)
                dir_q <= ~dir_q;
            if ((state == RUN || state == TURN) && mismatch)
                err_q <= 1'b1;
        end
    end

    // Sequence parameters captured at an accepted start; only read while busy.
    always_ff @(posedge clk) begin
        if (state == IDLE && start && !abort && accept) begin
            preset_q <= preset;
            mode_q   <= mode;
            passes_q <= passes;
        end
    end

    assign err = err_q;

    decade_mirror u_mirror (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (data_out),
        .enable   (counter_on),
        .up       (count_up),
        .value    (mirror_val),
        .tc       (mirror_tc)
    );

endmodule

// File: tb/tb_decade_ctrl.sv
// Scoreboarded bench: decade_ctrl driving a behavioural decade counter, directed and random sequences.
module tb_decade_ctrl;

    logic       clk = 1'b1;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] preset = 4'd0;
    logic [1:0] mode = 2'b00;
    logic [3:0] passes = 4'd1;
    logic       tc_in;
    logic [3:0] count_in;
    logic       load;
    logic [3:0] data_out;
    logic       counter_on;
    logic       count_up;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] cnt;
    logic       inject = 1'b0;

    int tests = 0;
    int fails = 0;
    int issued = 0;
    int pops = 0;
    int loads_seen = 0;

    logic [3:0] exp_data[$];
    logic       exp_err[$];
    logic       exp_abort[$];
    int         exp_len[$];
    logic [4:0] exp_tr[$];
    logic [4:0] obs[$];

    always #50 clk = ~clk;

    decade_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .preset     (preset),
        .mode       (mode),
        .passes     (passes),
        .tc_in      (tc_in),
        .count_in   (count_in),
        .load       (load),
        .data_out   (data_out),
        .counter_on (counter_on),
        .count_up   (count_up),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Team decade counter (behavioural)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= 4'd0;
        else if (load)
            cnt <= data_out;
        else if (counter_on)
            cnt <= count_up ? ((cnt == 4'd9) ? 4'd0 : cnt + 4'd1)
                            : ((cnt == 4'd0) ? 4'd9 : cnt - 4'd1);
    end
    assign tc_in    = count_up ? (cnt == 4'd9) : (cnt == 4'd0);
    assign count_in = inject ? 4'd5 : cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected per-cycle {direction, count} while busy after the load cycle.
    task automatic model_trace(input int p, input int m, input int n);
        int v = p;
        bit up = (m != 1);
        int pc = 0;
        int len = 0;
        forever begin
            exp_tr.push_back({up, 4'(v)});
            len++;
            if (up ? (v == 9) : (v == 0)) begin
                pc++;
                if (pc == n) break;
                if (m == 2) begin
                    exp_tr.push_back({up, 4'(v)});
                    len++;
                    up = !up;
                    continue;
                end
            end
            v = up ? (v + 1) % 10 : (v + 9) % 10;
        end
        exp_len.push_back(len);
    endtask

    task automatic issue(input int p, input int m, input int n, input bit e, input bit ab);
        exp_data.push_back(4'(p));
        exp_err.push_back(e);
        exp_abort.push_back(ab);
        if (ab) exp_len.push_back(0);
        else model_trace(p, m, n);
        issued++;
        @(negedge clk);
        preset = 4'(p); mode = 2'(m); passes = 4'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (pops < issued && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (pops < issued) begin
            $display("FAIL timeout: got %0d completions, expected %0d", pops, issued);
            fails++;
            tests++;
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        @(negedge clk);
    endtask

    task automatic illegal_start(input logic [3:0] p, input logic [1:0] m, input logic [3:0] n);
        int l0 = loads_seen;
        @(negedge clk);
        preset = p; mode = m; passes = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_err", err, 1);
        check("illegal_idle", busy, 0);
        repeat (2) @(negedge clk);
        check("illegal_noload", loads_seen, l0);
    endtask

    // Monitor / scoreboard
    logic busy_d = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (load) begin
                loads_seen++;
                if (exp_data.size() == 0) begin
                    check("unexpected_load", 1, 0);
                end else begin
                    check("load_data", data_out, exp_data[0]);
                end
                obs.delete();
            end else if (busy) begin
                obs.push_back({count_up, cnt});
            end
            if (busy_d && !busy && exp_len.size() != 0) begin
                automatic logic ab = exp_abort.pop_front();
                automatic logic e  = exp_err.pop_front();
                automatic int   n  = exp_len.pop_front();
                void'(exp_data.pop_front());
                if (ab) begin
                    check("abort_no_done", done, 0);
                end else begin
                    automatic int bad = -1;
                    check("done_pulse", done, 1);
                    check("done_err", err, e);
                    check("trace_len", obs.size(), n);
                    for (int i = 0; i < n; i++) begin
                        automatic logic [4:0] x = exp_tr.pop_front();
                        if (bad < 0 && (i >= obs.size() || obs[i] !== x)) bad = i;
                    end
                    if (bad >= 0)
                        check("trace_elem", (bad < obs.size()) ? obs[bad] : 32'hFFFF,
                              exp_tr.size() >= 0 ? 32'(bad) * 0 + 32'(obs.size() > bad ? 999 : 998) : 0);
                    else
                        check("trace_ok", obs.size(), n);
                end
                pops++;
            end
            busy_d = busy;
        end
    end

    initial begin
        int k;
        bit prev_off;
        #120;
        check("rst_outputs", {load, data_out, counter_on, count_up, busy, done, err}, 0);
        #30 reset = 1'b1;
        @(negedge clk);
        check("post_rst_outputs", {load, data_out, counter_on, count_up, busy, done, err}, 0);

        issue(8, 0, 2, 0, 0);
        wait_done(400);
        issue(6, 2, 3, 0, 0);
        wait_done(400);

        illegal_start(4'd12, 2'b00, 4'd1);
        issue(3, 1, 1, 0, 0);
        check("err_cleared", err, 0);
        wait_done(400);
        illegal_start(4'd4, 2'b11, 4'd2);
        illegal_start(4'd4, 2'b00, 4'd0);

        issue(7, 1, 1, 1, 0);
        k = 0;
        while (!(cnt == 4'd4 && counter_on) && k < 50) begin @(negedge clk); k++; end
        check("mismatch_reach", cnt, 4);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check("mismatch_err", err, 1);
        wait_done(400);

        issue(2, 0, 3, 0, 1);
        repeat (5) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_cnt_on", counter_on, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        wait_done(10);

        issue(8, 2, 3, 0, 1);
        k = 0; prev_off = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (busy && !load && !counter_on && prev_off) break;
            prev_off = busy && !load && !counter_on;
        end
        check("turn_hold", cnt, 9);
        reset = 1'b0;
        #1;
        check("rst_turn_outputs", {load, data_out, counter_on, count_up, busy, done, err}, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_done(10);

        for (int i = 0; i < 24; i++) begin
            if (i % 5 == 4) begin
                case ($urandom_range(0, 2))
                    0: illegal_start(4'($urandom_range(10, 15)), 2'b00, 4'd3);
                    1: illegal_start(4'($urandom_range(0, 9)), 2'b11, 4'd3);
                    default: illegal_start(4'($urandom_range(0, 9)), 2'b10, 4'd0);
                endcase
            end
            issue($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(1, 15), 0, 0);
            wait_done(400);
        end

        check("queue_empty", exp_tr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
